// File: rtl/dit4_bfly_sched.sv
// Radix-4 DIT butterfly issue scheduler: one butterfly per cycle, stage-by-stage with drain (optional DIT4_SCHED_BITREV_EN).
// Latency: first rd_en one cycle after start; wr_en trails each rd_en by PIPE_LAT cycles.
// Backpressure: hold=1 stalls issue during ISSUE only; in-flight butterflies always complete.
module dit4_bfly_sched #(
    parameter int LOG4N      = 3,
    parameter int ADDR_WIDTH = 2*LOG4N,
    parameter int PIPE_LAT   = 5,
    localparam int BW = ADDR_WIDTH - 2,
    localparam int SW = (LOG4N > 1) ? $clog2(LOG4N) : 1,
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  hold,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr0,
    output logic [ADDR_WIDTH-1:0] rd_addr1,
    output logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [ADDR_WIDTH-1:0] rd_addr3,
    output logic [BW-1:0]         tw_idx,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr0,
    output logic [ADDR_WIDTH-1:0] wr_addr1,
    output logic [ADDR_WIDTH-1:0] wr_addr2,
    output logic [ADDR_WIDTH-1:0] wr_addr3,
    output logic [SW-1:0]         stage,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [BW-1:0] B_LAST = {BW{1'b1}};
    localparam logic [SW-1:0] S_LAST = SW'(LOG4N - 1);
    localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [BW-1:0]   b_q, b_d;
    logic [DW-1:0]   d_q, d_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
            d_q     <= d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        d_d     = d_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    s_d     = '0;
                    b_d     = '0;
                end
            end
            ISSUE: begin
                if (!hold) begin
                    if (b_q == B_LAST) begin
                        state_d = DRAIN;
                        d_d     = '0;
                    end else begin
                        b_d = b_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Wait until the last butterfly of this stage has been written back.
                if (d_q == D_LAST) begin
                    if (s_q == S_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        s_d     = s_q + 1'b1;
                        b_d     = '0;
                    end
                end else begin
                    d_d = d_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_en = (state_q == ISSUE) && !hold;
    assign stage = s_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

    // Two zero bits are inserted at position 2s; leg m fills them, so no carries occur.
    logic [ADDR_WIDTH-1:0] b_ext, span, lo_mask, base;
    logic [ADDR_WIDTH-1:0] rd_addr [4];
    logic [BW-1:0]         tw_raw;

    always_comb begin
        b_ext   = {2'b00, b_q};
        span    = ADDR_WIDTH'(1) << (2*s_q);
        lo_mask = span - 1'b1;
        base    = ((b_ext & ~lo_mask) << 2) | (b_ext & lo_mask);
        tw_raw  = BW'((b_ext & lo_mask) << (2*(LOG4N-1) - 2*int'(s_q)));
        for (int m = 0; m < 4; m++) begin
            rd_addr[m] = rd_en ? (base | (ADDR_WIDTH'(m) << (2*s_q))) : '0;
        end
    end

    assign rd_addr0 = rd_addr[0];
    assign rd_addr1 = rd_addr[1];
    assign rd_addr2 = rd_addr[2];
    assign rd_addr3 = rd_addr[3];
    assign tw_idx   = rd_en ? tw_raw : '0;

    logic [PIPE_LAT-1:0]   vld_pipe;
    logic [ADDR_WIDTH-1:0] addr_pipe [PIPE_LAT][4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                for (int m = 0; m < 4; m++) begin
                    addr_pipe[i][m] <= '0;
                end
            end
        end else begin
            vld_pipe[0] <= rd_en;
            for (int m = 0; m < 4; m++) begin
                addr_pipe[0][m] <= rd_addr[m];
            end
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                for (int m = 0; m < 4; m++) begin
                    addr_pipe[i][m] <= addr_pipe[i-1][m];
                end
            end
        end
    end

    assign wr_en = vld_pipe[PIPE_LAT-1];

    logic [ADDR_WIDTH-1:0] wr_addr [4];

`ifdef DIT4_SCHED_BITREV_EN
    function automatic logic [ADDR_WIDTH-1:0] digit_rev(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < LOG4N; i++) begin
            r[2*i +: 2] = a[2*(LOG4N-1-i) +: 2];
        end
        return r;
    endfunction

    // Final-stage writes all land before s advances, so the live stage selects the reversal.
    always_comb begin
        for (int m = 0; m < 4; m++) begin
            wr_addr[m] = (s_q == S_LAST) ? digit_rev(addr_pipe[PIPE_LAT-1][m])
                                         : addr_pipe[PIPE_LAT-1][m];
        end
    end
`else
    always_comb begin
        for (int m = 0; m < 4; m++) begin
            wr_addr[m] = addr_pipe[PIPE_LAT-1][m];
        end
    end
`endif

    assign wr_addr0 = wr_addr[0];
    assign wr_addr1 = wr_addr[1];
    assign wr_addr2 = wr_addr[2];
    assign wr_addr3 = wr_addr[3];

endmodule

// File: tb/tb_dit4_bfly_sched.sv
// Bench for dit4_bfly_sched: directed scenarios, a vector table and randomized hold/start against a schedule model.
module tb_dit4_bfly_sched;

    localparam int LOG4N = 3;
    localparam int AW    = 6;
    localparam int L     = 5;
    localparam int Q     = 16;
    localparam int TOTAL = 48;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic          rd_en, wr_en, busy, done;
    logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
    logic [AW-1:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3;
    logic [AW-3:0] tw_idx;
    logic [1:0]    stage;

    always #5 clk = ~clk;

    dit4_bfly_sched #(.LOG4N(LOG4N), .ADDR_WIDTH(AW), .PIPE_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
        .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_addr2(rd_addr2), .rd_addr3(rd_addr3), .tw_idx(tw_idx),
        .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
        .wr_addr2(wr_addr2), .wr_addr3(wr_addr3),
        .stage(stage), .busy(busy), .done(done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Schedule model: butterflies issued so far, drain gap remaining, stage shown.
    bit m_active = 1'b0;
    int issued, gap, m_stage, rel;

    typedef struct packed {
        int due;
        int s;
        int b;
        logic [3:0][AW-1:0] a;
    } wr_t;
    wr_t wq[$];

    int rd_cnt, wr_cnt, done_cnt, done_rel;
    int first_rd [3];
    int last_wr  [3];
    int cap_rd [3][16][4];
    int cap_wr [3][16][4];
    int cap_tw [3][16];

    typedef struct packed {
        int s;
        int b;
        int tw;
        logic [3:0][7:0] a;
        logic [3:0][7:0] w;
    } vec_t;
    vec_t vt [8];

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int exp_addr(input int s, input int b, input int m);
        int span;
        span = 1 << (2*s);
        return (b / span) * 4 * span + m * span + (b % span);
    endfunction

    function automatic int exp_tw(input int s, input int b);
        int span;
        span = 1 << (2*s);
        return ((b % span) * (1 << (2*(LOG4N-1-s)))) % Q;
    endfunction

    function automatic int rev4(input int a);
        int r;
        r = 0;
        for (int i = 0; i < LOG4N; i++) begin
            r = r + ((a / (1 << (2*i))) % 4) * (1 << (2*(LOG4N-1-i)));
        end
        return r;
    endfunction

    function automatic int exp_wr(input int s, input int b, input int m);
`ifdef DIT4_SCHED_BITREV_EN
        if (s == LOG4N-1) return rev4(exp_addr(s, b, m));
`endif
        return exp_addr(s, b, m);
    endfunction

    function automatic vec_t mk(input int s, input int b, input int tw,
                                input int a0, input int a1, input int a2, input int a3,
                                input int w0, input int w1, input int w2, input int w3);
        vec_t v;
        v.s = s; v.b = b; v.tw = tw;
        v.a[0] = 8'(a0); v.a[1] = 8'(a1); v.a[2] = 8'(a2); v.a[3] = 8'(a3);
        v.w[0] = 8'(w0); v.w[1] = 8'(w1); v.w[2] = 8'(w2); v.w[3] = 8'(w3);
        return v;
    endfunction

    task automatic monitor();
        bit  e_rd, e_done;
        int  s, b;
        int  ar [4];
        int  aw [4];
        wr_t w;
        e_rd = 1'b0;
        e_done = 1'b0;
        ar[0] = int'(rd_addr0); ar[1] = int'(rd_addr1); ar[2] = int'(rd_addr2); ar[3] = int'(rd_addr3);
        aw[0] = int'(wr_addr0); aw[1] = int'(wr_addr1); aw[2] = int'(wr_addr2); aw[3] = int'(wr_addr3);
        if (m_active) begin
            rel++;
            if (issued == TOTAL && gap == 0) e_done = 1'b1;
            else if (gap == 0 && !hold) e_rd = 1'b1;
            chk("busy", int'(busy), 1);
            chk("stage", int'(stage), m_stage);
        end else begin
            chk("busy_idle", int'(busy), 0);
        end
        chk("rd_en", int'(rd_en), int'(e_rd));
        chk("done", int'(done), int'(e_done));
        if (done) begin
            done_cnt++;
            done_rel = rel;
        end
        if (rd_en) rd_cnt++;
        if (e_rd) begin
            s = issued / Q;
            b = issued % Q;
            for (int m = 0; m < 4; m++) begin
                chk($sformatf("rd_addr%0d s%0d b%0d", m, s, b), ar[m], exp_addr(s, b, m));
                cap_rd[s][b][m] = ar[m];
                w.a[m] = AW'(exp_wr(s, b, m));
            end
            chk("tw_idx", int'(tw_idx), exp_tw(s, b));
            cap_tw[s][b] = int'(tw_idx);
            if (b == 0) first_rd[s] = rel;
            w.due = cyc + L;
            w.s = s;
            w.b = b;
            wq.push_back(w);
        end
        if (wq.size() > 0 && wq[0].due == cyc) begin
            w = wq.pop_front();
            chk("wr_en", int'(wr_en), 1);
            for (int m = 0; m < 4; m++) begin
                chk($sformatf("wr_addr%0d s%0d b%0d", m, w.s, w.b), aw[m], int'(w.a[m]));
                cap_wr[w.s][w.b][m] = aw[m];
            end
            last_wr[w.s] = rel;
        end else begin
            chk("wr_en_quiet", int'(wr_en), 0);
        end
        if (wr_en) wr_cnt++;
        if (m_active) begin
            if (e_done) begin
                m_active = 1'b0;
            end else if (e_rd) begin
                issued++;
                if (issued % Q == 0) gap = L;
            end else if (gap > 0) begin
                gap--;
                if (gap == 0 && issued < TOTAL) m_stage++;
            end
        end else if (start) begin
            m_active = 1'b1;
            issued = 0; gap = 0; m_stage = 0; rel = 0;
            rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_rel = -1;
            for (int i = 0; i < 3; i++) begin
                first_rd[i] = -1;
                last_wr[i] = -1;
            end
        end
    endtask

    task automatic tick(input bit h, input bit st);
        hold = h;
        start = st;
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_rd_addr0"}, int'(rd_addr0), 0);
        chk({tag, "_rd_addr1"}, int'(rd_addr1), 0);
        chk({tag, "_rd_addr2"}, int'(rd_addr2), 0);
        chk({tag, "_rd_addr3"}, int'(rd_addr3), 0);
        chk({tag, "_tw_idx"}, int'(tw_idx), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_wr_addr0"}, int'(wr_addr0), 0);
        chk({tag, "_wr_addr1"}, int'(wr_addr1), 0);
        chk({tag, "_wr_addr2"}, int'(wr_addr2), 0);
        chk({tag, "_wr_addr3"}, int'(wr_addr3), 0);
        chk({tag, "_stage"}, int'(stage), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        vt[0] = mk(0, 5, 0, 20, 21, 22, 23, 20, 21, 22, 23);
        vt[1] = mk(1, 5, 4, 17, 21, 25, 29, 17, 21, 25, 29);
        vt[2] = mk(0, 15, 0, 60, 61, 62, 63, 60, 61, 62, 63);
        vt[3] = mk(1, 10, 8, 34, 38, 42, 46, 34, 38, 42, 46);
`ifdef DIT4_SCHED_BITREV_EN
        vt[4] = mk(2, 5, 5, 5, 21, 37, 53, 20, 21, 22, 23);
        vt[5] = mk(2, 6, 6, 6, 22, 38, 54, 36, 37, 38, 39);
        vt[6] = mk(2, 15, 15, 15, 31, 47, 63, 60, 61, 62, 63);
`else
        vt[4] = mk(2, 5, 5, 5, 21, 37, 53, 5, 21, 37, 53);
        vt[5] = mk(2, 6, 6, 6, 22, 38, 54, 6, 22, 38, 54);
        vt[6] = mk(2, 15, 15, 15, 31, 47, 63, 15, 31, 47, 63);
`endif
        vt[7] = mk(1, 0, 0, 0, 4, 8, 12, 0, 4, 8, 12);

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        tick(1'b0, 1'b0);

        // Full transform, no hold.
        tick(1'b0, 1'b1);
        for (int k = 1; k <= 66; k++) tick(1'b0, 1'b0);
        chk("rd_cnt", rd_cnt, 48);
        chk("wr_cnt", wr_cnt, 48);
        chk("done_cnt", done_cnt, 1);
        chk("done_cycle", done_rel, 64);
        chk("first_rd0", first_rd[0], 1);
        chk("first_rd1", first_rd[1], 22);
        chk("first_rd2", first_rd[2], 43);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("hazard_gap s%0d", s), first_rd[s+1] - last_wr[s], 1);
        end
        for (int i = 0; i < 8; i++) begin
            for (int m = 0; m < 4; m++) begin
                chk($sformatf("vec%0d rd%0d", i, m), cap_rd[vt[i].s][vt[i].b][m], int'(vt[i].a[m]));
                chk($sformatf("vec%0d wr%0d", i, m), cap_wr[vt[i].s][vt[i].b][m], int'(vt[i].w[m]));
            end
            chk($sformatf("vec%0d tw", i), cap_tw[vt[i].s][vt[i].b], vt[i].tw);
        end

        // Three hold cycles inside stage 1 issue.
        tick(1'b0, 1'b1);
        for (int k = 1; k <= 70; k++) tick(k >= 26 && k <= 28, 1'b0);
        chk("hold_rd_cnt", rd_cnt, 48);
        chk("hold_wr_cnt", wr_cnt, 48);
        chk("hold_done_cycle", done_rel, 67);
        chk("hold_done_cnt", done_cnt, 1);

        // Reset during stage 1 drain, then rerun with stray starts while busy.
        tick(1'b0, 1'b1);
        for (int k = 1; k <= 39; k++) tick(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        m_active = 1'b0;
        wq.delete();
        @(posedge clk);
        cyc++;
        #1;
        check_zero("abort_held");
        rst_n = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int k = 1; k <= 66; k++) tick(1'b0, k == 10 || k == 40);
        chk("rerun_rd_cnt", rd_cnt, 48);
        chk("rerun_done_cycle", done_rel, 64);
        chk("rerun_done_cnt", done_cnt, 1);

        // Randomized hold and stray start pulses.
        for (int r = 0; r < 6; r++) begin
            int idle;
            idle = $urandom_range(0, 3);
            for (int k = 0; k < idle; k++) tick(1'($urandom_range(0, 1)), 1'b0);
            tick(1'($urandom_range(0, 1)), 1'b1);
            for (int k = 0; k < 400 && m_active; k++) begin
                tick($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            end
            chk($sformatf("rand%0d_complete", r), int'(m_active), 0);
            chk($sformatf("rand%0d_rd_cnt", r), rd_cnt, 48);
            chk($sformatf("rand%0d_done_cnt", r), done_cnt, 1);
        end
        tick(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
